// File: rtl/dvi_sync_decoder.sv
// DVI receive-side sync decoder: rebuilds pixel coordinates from a registered
// hsync/vsync/de/rgb stream, checks active geometry and reports lock/errors.
module dvi_sync_decoder #(
  parameter int unsigned CORDW       = 10,
  parameter int unsigned H_RES       = 640,
  parameter int unsigned V_RES       = 480,
  parameter int unsigned H_POL       = 0,
  parameter int unsigned V_POL       = 0,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             hsync_i,
  input  logic             vsync_i,
  input  logic             de_i,
  input  logic [11:0]      rgb_i,
  output logic             de_o,
  output logic [CORDW-1:0] sx_o,
  output logic [CORDW-1:0] sy_o,
  output logic [11:0]      rgb_o,
  output logic             line_o,
  output logic             frame_o,
  output logic             locked_o,
  output logic             err_o,
  output logic [7:0]       err_count_o
);

  localparam int unsigned LW = CORDW + 1;
  localparam int unsigned GW = 4;
  localparam int unsigned EW = 8;
  localparam logic [CORDW-1:0] C_MAX  = {CORDW{1'b1}};
  localparam logic [LW-1:0]    H_LEN  = LW'(H_RES);
  localparam logic [LW-1:0]    V_LEN  = LW'(V_RES);
  localparam logic [GW-1:0]    G_LOCK = GW'(LOCK_FRAMES);
  localparam logic [EW-1:0]    E_MAX  = {EW{1'b1}};

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  // input stage
  logic        hs_act_c;
  logic        vs_act_c;
  logic        hs_q;
  logic        vs_q;
  logic        de_q;
  logic [11:0] rgb_q;
  logic        vs_p;
  logic        de_p;

  // edge detection
  logic vs_start_c;
  logic de_rise_c;
  logic de_fall_c;

  // coordinate counters
  logic [CORDW-1:0] sx_q;
  logic [CORDW-1:0] sx_c;
  logic [CORDW-1:0] sy_q;
  logic [CORDW-1:0] sy_n;

  // geometry checks
  logic [LW-1:0] line_len_c;
  logic [LW-1:0] lines_c;
  logic          line_fail_c;
  logic          overlap_c;
  logic          frame_ok_c;
  logic          frame_fail_c;
  logic          frame_bad_q;
  logic          frame_bad_n;

  // lock FSM
  state_t        state_q;
  state_t        state_n;
  logic [GW-1:0] good_cnt_q;
  logic [GW-1:0] good_cnt_n;
  logic          skip_q;
  logic          skip_n;
  logic          locked_c;
  logic          err_c;
  logic          err_d_q;

  // Normalise sync levels so that 1 always means "active".
  assign hs_act_c = (H_POL != 0) ? hsync_i : ~hsync_i;
  assign vs_act_c = (V_POL != 0) ? vsync_i : ~vsync_i;

  // Input register plus one-cycle history for edge detection.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
      de_q  <= 1'b0;
      rgb_q <= 12'h000;
      vs_p  <= 1'b0;
      de_p  <= 1'b0;
    end else begin
      hs_q  <= hs_act_c;
      vs_q  <= vs_act_c;
      de_q  <= de_i;
      rgb_q <= rgb_i;
      vs_p  <= vs_q;
      de_p  <= de_q;
    end
  end

  assign vs_start_c = vs_q & ~vs_p;
  assign de_rise_c  = de_q & ~de_p;
  assign de_fall_c  = ~de_q & de_p;

  // Column for the pixel currently in the input register.
  always_comb begin
    sx_c = sx_q;
    if (de_rise_c) begin
      sx_c = '0;
    end else if (de_q && (sx_q != C_MAX)) begin
      sx_c = sx_q + CORDW'(1);
    end
  end

  // Row counter: completed lines since the last vs_start.
  always_comb begin
    sy_n = sy_q;
    if (vs_start_c) begin
      sy_n = '0;
    end else if (de_fall_c && (sy_q != C_MAX)) begin
      sy_n = sy_q + CORDW'(1);
    end
  end

  // A line ending together with vs_start still belongs to the ending frame.
  assign line_len_c   = {1'b0, sx_q} + LW'(1);
  assign lines_c      = {1'b0, sy_q} + LW'(de_fall_c);
  assign line_fail_c  = de_fall_c && (line_len_c != H_LEN);
  assign overlap_c    = de_q && hs_q;
  assign frame_ok_c   = !frame_bad_q && !line_fail_c && !overlap_c && (lines_c == V_LEN);
  // After a lock drop on a bad line, that frame was already reported once.
  assign frame_fail_c = vs_start_c && !skip_q && !frame_ok_c;

  // Frame-bad accumulates line and overlap faults until the next vs_start.
  always_comb begin
    frame_bad_n = frame_bad_q | line_fail_c | overlap_c;
    if (vs_start_c) begin
      frame_bad_n = 1'b0;
    end
  end

  // Counter and frame-bad state.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      sx_q        <= '0;
      sy_q        <= '0;
      frame_bad_q <= 1'b0;
    end else begin
      sx_q        <= sx_c;
      sy_q        <= sy_n;
      frame_bad_q <= frame_bad_n;
    end
  end

  // Lock FSM state register.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q    <= SEARCH;
      good_cnt_q <= '0;
      skip_q     <= 1'b0;
    end else begin
      state_q    <= state_n;
      good_cnt_q <= good_cnt_n;
      skip_q     <= skip_n;
    end
  end

  // Lock FSM next-state logic.
  always_comb begin
    state_n    = state_q;
    good_cnt_n = good_cnt_q;
    skip_n     = skip_q;
    case (state_q)
      SEARCH: begin
        if (vs_start_c) begin
          state_n    = MEASURE;
          good_cnt_n = '0;
          skip_n     = 1'b0;
        end
      end
      MEASURE: begin
        if (vs_start_c) begin
          skip_n = 1'b0;
          if (skip_q || !frame_ok_c) begin
            good_cnt_n = '0;
          end else begin
            good_cnt_n = good_cnt_q + GW'(1);
            if (good_cnt_n == G_LOCK) begin
              state_n = LOCKED;
            end
          end
        end
      end
      LOCKED: begin
        if (line_fail_c || frame_fail_c) begin
          state_n    = MEASURE;
          good_cnt_n = '0;
          skip_n     = line_fail_c && !vs_start_c;
        end
      end
      default: begin
        state_n    = SEARCH;
        good_cnt_n = '0;
        skip_n     = 1'b0;
      end
    endcase
  end

  // Lock FSM outputs: lock level and error event.
  always_comb begin
    locked_c = 1'b0;
    err_c    = 1'b0;
    case (state_q)
      MEASURE: begin
        err_c = line_fail_c || frame_fail_c;
      end
      LOCKED: begin
        locked_c = 1'b1;
        err_c    = line_fail_c || frame_fail_c;
      end
      default: begin
        locked_c = 1'b0;
        err_c    = 1'b0;
      end
    endcase
  end

  // Output register for pixel stream, status and saturating error count.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      de_o        <= 1'b0;
      sx_o        <= '0;
      sy_o        <= '0;
      rgb_o       <= 12'h000;
      line_o      <= 1'b0;
      frame_o     <= 1'b0;
      locked_o    <= 1'b0;
      err_d_q     <= 1'b0;
      err_o       <= 1'b0;
      err_count_o <= '0;
    end else begin
      de_o     <= de_q;
      sx_o     <= sx_c;
      sy_o     <= sy_q;
      rgb_o    <= rgb_q;
      line_o   <= de_rise_c;
      frame_o  <= de_rise_c && (sy_q == '0);
      locked_o <= locked_c;
      err_d_q  <= err_c;
      err_o    <= err_d_q;
      if (err_d_q && (err_count_o != E_MAX)) begin
        err_count_o <= err_count_o + EW'(1);
      end
    end
  end

endmodule
